// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serial pattern-detect controller.
//   state_t     - controller FSM encoding
//   LEN_W       - width of the pattern-length field and of the history fill count
//   PAT_RST_DEF - pattern value loaded at reset
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int LEN_W = 3;

    localparam logic [5:0] PAT_RST_DEF = 6'b101010;

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial history shift register, fill count and masked pattern compare.
//   clk, reset  - clock, synchronous active-high reset
//   shift_en    - shift x into the history this cycle
//   clr         - clear history and fill count (wins over shift_en)
//   x           - serial data bit
//   pattern     - pattern to match; only the low len bits are compared
//   len         - pattern length, already clamped to 1..PAT_W
//   hit         - combinational: the history after this shift matches
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PAT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_nxt;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_nxt;
    logic             eq;

    // The compare looks at the history as it will be after this shift, so the
    // match is known in the sampling cycle and z can be registered on that edge.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], x};
        fill_nxt = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + LEN_W'(1);
        eq       = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if ((i < int'(len)) && (hist_nxt[i] != pattern[i])) begin
                eq = 1'b0;
            end
        end
        hit = shift_en && eq && (fill_nxt >= len);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern-detect controller.
//   clk, reset   - clock, synchronous active-high reset
//   cfg_we       - write all config fields (taken only in IDLE)
//   cfg_pattern  - pattern; pattern[len-1] is the first bit received
//   cfg_len      - pattern length; 0 or > PAT_W means PAT_W
//   cfg_overlap  - 1: overlapping matches, 0: history restarts after a match
//   cfg_target   - matches before DONE; 0 = unlimited
//   start        - arm detection from IDLE or DONE
//   abort        - back to IDLE from any state (beats start)
//   x, x_valid   - serial data and its qualifier
//   z            - registered one-cycle match pulse
//   busy, done   - ARMED / DONE status
//   match_cnt    - saturating match count since the last start
//
// state | meaning
// IDLE  | disarmed; config writes accepted
// ARMED | sampling x, counting matches
// DONE  | target count reached; x ignored, waits for start or abort
module seq_det_ctrl
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 6,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             cfg_wr;
    logic             start_take;
    logic             shift_en;
    logic             clr;
    logic             hit;

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .clr      (clr),
        .x        (x),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        state_nxt   = state;
        cfg_wr      = cfg_we && (state == IDLE);
        start_take  = start && !abort && (state != ARMED);
        shift_en    = (state == ARMED) && x_valid && !abort;
        clr         = start_take || (hit && !ovl_q);
        cnt_inc     = (&match_cnt) ? match_cnt : match_cnt + CNT_W'(1);
        len_clamped = ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : cfg_len;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ARMED;
                ARMED:   if (hit && (tgt_q != '0) && (cnt_inc == tgt_q)) state_nxt = DONE;
                DONE:    if (start) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= PAT_RST;
            len_q     <= LEN_W'(PAT_W);
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
            match_cnt <= '0;
            z         <= 1'b0;
        end else begin
            state <= state_nxt;
            z     <= hit;
            if (cfg_wr) begin
                pat_q <= cfg_pattern;
                len_q <= len_clamped;
                ovl_q <= cfg_overlap;
                tgt_q <= cfg_target;
            end
            if (start_take) begin
                match_cnt <= '0;
            end else if (hit) begin
                match_cnt <= cnt_inc;
            end
        end
    end

    assign busy = (state == ARMED);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: table-driven bench for seq_det_ctrl. Each table row is one
// clock cycle of inputs plus the hand-computed outputs expected after that edge.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       z;
    logic       busy;
    logic       done;
    logic [7:0] match_cnt;

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .match_cnt   (match_cnt)
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic       we;
        logic [5:0] pat;
        logic [2:0] len;
        logic       ovl;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       xv;
        logic       xb;
        logic       ez;
        logic       eb;
        logic       ed;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    int n_cmp = 0;
    int n_bad = 0;

    string      tag = "";
    logic [5:0] b_pat = 6'b101010;
    logic [2:0] b_len = 3'd6;
    logic       b_ovl = 1'b1;
    logic [7:0] b_tgt = 8'd0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;
    logic [7:0] e_cnt = 8'd0;

    task automatic add(input logic rst, we, st, ab, xv, xb, ez);
        vec_t r;
        r.tag = tag; r.rst = rst; r.we = we; r.pat = b_pat; r.len = b_len;
        r.ovl = b_ovl; r.tgt = b_tgt; r.st = st; r.ab = ab; r.xv = xv; r.xb = xb;
        r.ez = ez; r.eb = e_busy; r.ed = e_done; r.ec = e_cnt;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        e_busy = 1'b0; e_done = 1'b0; e_cnt = 8'd0;
        add(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        e_busy = 1'b1; e_done = 1'b0; e_cnt = 8'd0;
        add(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_abort(input logic xv, input logic xb);
        e_busy = 1'b0; e_done = 1'b0;
        add(0, 0, 0, 1, xv, xb, 0);
    endtask

    task automatic do_cfg(input logic with_start);
        if (with_start) begin
            e_busy = 1'b1; e_done = 1'b0; e_cnt = 8'd0;
        end
        add(0, 1, with_start, 0, 0, 0, 0);
    endtask

    // bits/zmask are MSB-first; done_at is the 1-based bit that enters DONE
    // (0 = never); gap invalid cycles (with x inverted) follow every bit.
    task automatic send(input logic [15:0] bits, input int n, input logic [15:0] zmask,
                        input int done_at, input int gap);
        logic xb;
        logic zb;
        for (int i = 0; i < n; i++) begin
            xb = bits[n-1-i];
            zb = zmask[n-1-i];
            if (zb) e_cnt = e_cnt + 8'd1;
            if (i + 1 == done_at) begin
                e_busy = 1'b0; e_done = 1'b1;
            end
            add(0, 0, 0, 0, 1, xb, zb);
            for (int g = 0; g < gap; g++) add(0, 0, 0, 0, 0, ~xb, 0);
        end
    endtask

    task automatic check(input string t, input int idx, input string nm,
                         input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] %s: got %0d, expected %0d", t, idx, nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; cfg_we = v.we; cfg_pattern = v.pat; cfg_len = v.len;
        cfg_overlap = v.ovl; cfg_target = v.tgt; start = v.st; abort = v.ab;
        x_valid = v.xv; x = v.xb;
        @(posedge clk);
        #1;
        check(v.tag, idx, "z", {7'd0, z}, {7'd0, v.ez});
        check(v.tag, idx, "busy", {7'd0, busy}, {7'd0, v.eb});
        check(v.tag, idx, "done", {7'd0, done}, {7'd0, v.ed});
        check(v.tag, idx, "match_cnt", match_cnt, v.ec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: default pattern, overlapping matches
        tag = "T1";
        do_reset();
        do_start();
        send(16'b101010101010, 12, 16'b000001010101, 0, 0);

        // T2: non-overlapping
        tag = "T2";
        do_abort(0, 0);
        b_ovl = 1'b0;
        do_cfg(0);
        do_start();
        send(16'b101010101010, 12, 16'b000001000001, 0, 0);

        // T3: target 2, then restart from DONE
        tag = "T3";
        do_abort(0, 0);
        b_ovl = 1'b1; b_tgt = 8'd2;
        do_cfg(0);
        do_start();
        send(16'b101010101010, 12, 16'b000001010000, 8, 0);
        do_start();
        send(16'b101010, 6, 16'b000001, 0, 0);
        do_abort(0, 0);

        // T6: write with start in the same cycle, write in ARMED ignored
        tag = "T6";
        b_pat = 6'b000101; b_len = 3'd3; b_tgt = 8'd0;
        do_cfg(1);
        b_pat = 6'b111111; b_len = 3'd1;
        add(0, 1, 0, 0, 0, 0, 0);
        send(16'b10101, 5, 16'b00101, 0, 0);

        // T4: reset restores config; gaps of invalid cycles
        tag = "T4";
        b_pat = 6'b101010; b_len = 3'd6; b_ovl = 1'b1; b_tgt = 8'd0;
        do_reset();
        do_start();
        send(16'b101010, 6, 16'b000001, 0, 3);

        // T5: abort on a would-be match bit; restart clears history
        tag = "T5";
        do_abort(0, 0);
        do_start();
        send(16'b10101, 5, 16'b0, 0, 0);
        do_abort(1, 0);
        do_start();
        send(16'b0, 1, 16'b0, 0, 0);
        send(16'b101010, 6, 16'b000001, 0, 0);

        // T7: length clamping (0 and 7 both mean 6)
        tag = "T7";
        do_abort(0, 0);
        b_pat = 6'b110011; b_len = 3'd0;
        do_cfg(1);
        send(16'b110011, 6, 16'b000001, 0, 0);
        do_abort(0, 0);
        b_pat = 6'b011100; b_len = 3'd7;
        do_cfg(1);
        send(16'b011100, 6, 16'b000001, 0, 0);

        // T8: 1-bit pattern, 260 matches saturate the counter at 255
        tag = "T8";
        do_abort(0, 0);
        b_pat = 6'b000001; b_len = 3'd1;
        do_cfg(1);
        for (int i = 0; i < 260; i++) begin
            if (e_cnt != 8'd255) e_cnt = e_cnt + 8'd1;
            add(0, 0, 0, 0, 1, 1, 1);
        end
        do_abort(0, 0);

        #2;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
